// File: rtl/mult24_pkg.sv
// Shared types and helpers for the mantissa-multiplier arbiter.
package mult24_pkg;

    localparam int unsigned MANT_W  = 24;
    localparam int unsigned PROD_W  = 48;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned MAX_IDW = 3;

    typedef logic [MANT_W-1:0] mant_t;
    typedef logic [PROD_W-1:0] prod_t;

    // One-hot grant: first valid requester after ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic logic [MAX_REQ-1:0] next_rr(
        input logic [MAX_REQ-1:0] valid,
        input logic [MAX_IDW-1:0] ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = (32'(ptr) + k) % n;
                if (!found && valid[idx[MAX_IDW-1:0]]) begin
                    grant[idx[MAX_IDW-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mult24_arbiter_rr_arbiter.sv
// Round-robin grant generator; the priority pointer moves only when a grant is taken.
module rr_arbiter
    import mult24_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;

    always_comb begin
        grant = N'(next_rr(MAX_REQ'(req), MAX_IDW'(ptr), N));
    end

    // One-hot to index for the pointer update.
    always_comb begin
        gidx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) gidx = PW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= PW'(N - 1);
        end else if (advance) begin
            ptr <= gidx;
        end
    end

endmodule

// File: rtl/mult24_arbiter.sv
// Shares one external 24x24 multiplier among NREQ requesters through a two-stage
// operand/response pipeline with valid/ready on both sides.
module mult24_arbiter
    import mult24_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][MANT_W-1:0]  req_a,
    input  logic [NREQ-1:0][MANT_W-1:0]  req_b,
    output logic [MANT_W-1:0]            mul_a,
    output logic [MANT_W-1:0]            mul_b,
    input  logic [PROD_W-1:0]            mul_result,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [IDW-1:0]               resp_id,
    output logic [PROD_W-1:0]            resp_result
);

    logic            s1_v;
    logic [IDW-1:0]  s1_id;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    mant_t           sel_a;
    mant_t           sel_b;
    logic            s2_adv;
    logic            s1_free;
    logic            accept;

    always_comb begin
        s2_adv    = s1_v & (~resp_valid | resp_ready);
        s1_free   = ~s1_v | s2_adv;
        accept    = rst_n & s1_free & (|grant);
        req_ready = rst_n ? (grant & {NREQ{s1_free}}) : '0;
    end

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant)
    );

    // Grant is one-hot, so a priority-free mux picks the winner's operands.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        gidx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i];
                sel_b = req_b[i];
                gidx  = IDW'(i);
            end
        end
    end

    // S1: operands presented to the shared multiplier.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
            s1_id <= '0;
            s1_v  <= 1'b0;
        end else if (accept) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
            s1_id <= gidx;
            s1_v  <= 1'b1;
        end else if (s2_adv) begin
            s1_v  <= 1'b0;
        end
    end

    // S2: captured product, held until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_result <= '0;
            resp_id     <= '0;
            resp_valid  <= 1'b0;
        end else if (s2_adv) begin
            resp_result <= mul_result;
            resp_id     <= s1_id;
            resp_valid  <= 1'b1;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mult24_arbiter.sv
// Directed bench for mult24_arbiter with an in-order response scoreboard.
module tb_mult24_arbiter;
    import mult24_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0][MANT_W-1:0] req_a;
    logic [NREQ-1:0][MANT_W-1:0] req_b;
    logic [MANT_W-1:0]           mul_a;
    logic [MANT_W-1:0]           mul_b;
    logic [PROD_W-1:0]           mul_result;
    logic                        resp_valid;
    logic                        resp_ready;
    logic [IDW-1:0]              resp_id;
    logic [PROD_W-1:0]           resp_result;

    int n_checks = 0;
    int n_pass   = 0;

    int          exp_id[$];
    logic [47:0] exp_prod[$];

    always #5 clk = ~clk;

    // Stand-in for the external combinational multiplier.
    assign mul_result = {24'd0, mul_a} * {24'd0, mul_b};

    mult24_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_result  (mul_result),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted pair must come back once, in order, with its ID.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_id.delete();
            exp_prod.delete();
        end else begin
            if (resp_valid && resp_ready) begin
                check("sb_nonempty", 64'(exp_id.size() != 0), 64'd1);
                if (exp_id.size() != 0) begin
                    check("sb_id", 64'(resp_id), 64'(exp_id.pop_front()));
                    check("sb_prod", 64'(resp_result), 64'(exp_prod.pop_front()));
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_id.push_back(i);
                    exp_prod.push_back({24'd0, req_a[i]} * {24'd0, req_b[i]});
                end
            end
        end
    end

    int          rr_order[5] = '{0, 1, 2, 3, 0};
    logic [47:0] rr_prod[4]  = '{48'h1100, 48'h2200, 48'h3300, 48'h4400};
    int          rel_ids[4]  = '{1, 2, 3, 0};
    logic [23:0] st_a[8] = '{24'h000001, 24'h000002, 24'h000010, 24'h001000,
                             24'hFFFFFF, 24'h000000, 24'h800000, 24'h123456};
    logic [23:0] st_b[8] = '{24'h000001, 24'h000003, 24'h000010, 24'h001000,
                             24'h000001, 24'hABCDEF, 24'h000002, 24'h000010};
    logic [47:0] st_p[8] = '{48'h1, 48'h6, 48'h100, 48'h1000000,
                             48'hFFFFFF, 48'h0, 48'h1000000, 48'h1234560};

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        // Reset values, with requests asserted during reset.
        step();
        req_valid = 4'hF;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        step();
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_result", 64'(resp_result), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Single request from requester 2.
        req_a[2] = 24'h000003;
        req_b[2] = 24'h000005;
        req_valid = 4'b0100;
        #1;
        check("t1_ready", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        check("t1_resp_valid_early", 64'(resp_valid), 64'd0);
        check("t1_mul_a", 64'(mul_a), 64'h3);
        check("t1_mul_b", 64'(mul_b), 64'h5);
        step();
        check("t1_resp_valid", 64'(resp_valid), 64'd1);
        check("t1_resp_id", 64'(resp_id), 64'd2);
        check("t1_resp_result", 64'(resp_result), 64'h00000000000F);
        step();
        check("t1_resp_valid_done", 64'(resp_valid), 64'd0);

        // Extreme and zero operands.
        req_a[0] = 24'hFFFFFF;
        req_b[0] = 24'hFFFFFF;
        req_valid = 4'b0001;
        #1;
        check("max_ready", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        step();
        check("max_id", 64'(resp_id), 64'd0);
        check("max_result", 64'(resp_result), 64'hFFFFFE000001);
        req_a[1] = 24'h800000;
        req_b[1] = 24'h800000;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        check("msb_id", 64'(resp_id), 64'd1);
        check("msb_result", 64'(resp_result), 64'h400000000000);
        req_a[3] = 24'h000000;
        req_b[3] = 24'h123456;
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        check("zero_valid", 64'(resp_valid), 64'd1);
        check("zero_id", 64'(resp_id), 64'd3);
        check("zero_result", 64'(resp_result), 64'd0);

        // Round robin over all four requesters, starting from reset.
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i] = 24'(32'h11 * (i + 1));
            req_b[i] = 24'h000100;
        end
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("rr_grant", 64'(req_ready), 64'd1 << rr_order[c]);
            step();
            if (c >= 1) begin
                check("rr_resp_id", 64'(resp_id), 64'(rr_order[c-1]));
                check("rr_resp_prod", 64'(resp_result), 64'(rr_prod[rr_order[c-1]]));
            end
        end
        req_valid = '0;
        step();
        check("rr_last_id", 64'(resp_id), 64'd0);
        check("rr_last_prod", 64'(resp_result), 64'h1100);

        // Back-pressure: S2 holds requester 0's result, S1 takes requester 1.
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        step();
        for (int h = 0; h < 5; h++) begin
            #1;
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_id", 64'(resp_id), 64'd0);
            check("bp_result", 64'(resp_result), 64'h1100);
            check("bp_mul_a", 64'(mul_a), 64'h22);
            step();
        end
        resp_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            step();
            check("rel_valid", 64'(resp_valid), 64'd1);
            check("rel_id", 64'(resp_id), 64'(rel_ids[r]));
            check("rel_prod", 64'(resp_result), 64'(rr_prod[rel_ids[r]]));
        end
        req_valid = '0;
        step();
        step();
        check("drain_valid", 64'(resp_valid), 64'd0);

        // Fill both stages, then reset mid-flight.
        resp_ready = 1'b0;
        req_valid  = 4'b0011;
        step();
        step();
        #1;
        check("full_ready", 64'(req_ready), 64'd0);
        check("full_valid", 64'(resp_valid), 64'd1);
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        check("midrst_ready", 64'(req_ready), 64'd0);
        step();
        check("midrst_valid", 64'(resp_valid), 64'd0);
        check("midrst_mul_a", 64'(mul_a), 64'd0);
        rst_n     = 1'b1;
        req_valid = 4'b1010;
        #1;
        check("ptr_reset_grant", 64'(req_ready), 64'b0010);
        req_a[3]   = 24'h000007;
        req_b[3]   = 24'h000009;
        req_valid  = 4'b1000;
        resp_ready = 1'b1;
        #1;
        check("post_rst_ready", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        check("post_rst_valid_early", 64'(resp_valid), 64'd0);
        step();
        check("post_rst_valid", 64'(resp_valid), 64'd1);
        check("post_rst_id", 64'(resp_id), 64'd3);
        check("post_rst_prod", 64'(resp_result), 64'h3F);

        // Requester 1 streaming back-to-back.
        for (int k = 0; k < 8; k++) begin
            req_a[1]  = st_a[k];
            req_b[1]  = st_b[k];
            req_valid = 4'b0010;
            #1;
            check("st_ready", 64'(req_ready), 64'b0010);
            step();
            if (k >= 1) begin
                check("st_id", 64'(resp_id), 64'd1);
                check("st_prod", 64'(resp_result), 64'(st_p[k-1]));
            end
        end
        req_valid = '0;
        step();
        check("st_last_prod", 64'(resp_result), 64'(st_p[7]));
        step();
        check("end_valid", 64'(resp_valid), 64'd0);
        check("sb_drain", 64'(exp_id.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
